// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one ALU among NREQ requesters, round-robin,
// with one operation in flight: grant, issue, wait latency, capture, respond.
// Ports: CLK, RST (async, active-low); REQ_VALID/READY plus per-lane
// REQ_MODE/CMD/INP_VALID/OPA/OPB/CIN; ALU_CE/INP_VALID/MODE/CMD/OPA/OPB/CIN
// to the ALU and ALU_RES/FLAGS back; RSP_VALID/READY/ID/RES/FLAGS; BUSY.
module alu_req_arbiter #(
   parameter int DW      = 8,
   parameter int CW      = 4,
   parameter int NREQ    = 4,
   parameter int LAT     = 1,
   parameter int MUL_LAT = 2,
   localparam int IDW    = $clog2(NREQ)
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [NREQ-1:0]     REQ_VALID,
   output logic [NREQ-1:0]     REQ_READY,
   input  logic [NREQ-1:0]     REQ_MODE,
   input  logic [NREQ*CW-1:0]  REQ_CMD,
   input  logic [NREQ*2-1:0]   REQ_INP_VALID,
   input  logic [NREQ*DW-1:0]  REQ_OPA,
   input  logic [NREQ*DW-1:0]  REQ_OPB,
   input  logic [NREQ-1:0]     REQ_CIN,
   output logic                ALU_CE,
   output logic [1:0]          ALU_INP_VALID,
   output logic                ALU_MODE,
   output logic [CW-1:0]       ALU_CMD,
   output logic [DW-1:0]       ALU_OPA,
   output logic [DW-1:0]       ALU_OPB,
   output logic                ALU_CIN,
   input  logic [2*DW-1:0]     ALU_RES,
   input  logic [5:0]          ALU_FLAGS,
   output logic                RSP_VALID,
   input  logic                RSP_READY,
   output logic [IDW-1:0]      RSP_ID,
   output logic [2*DW-1:0]     RSP_RES,
   output logic [5:0]          RSP_FLAGS,
   output logic                BUSY
);

   localparam int MAXL = (LAT > MUL_LAT) ? LAT : MUL_LAT;
   localparam int CNTW = $clog2(MAXL + 1);

   if (LAT < 1 || MUL_LAT < 1) begin : g_bad_lat
      $error("alu_req_arbiter: LAT and MUL_LAT must be >= 1");
   end
   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("alu_req_arbiter: NREQ must be in 2..8");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CAPT,
      S_RESP
   } state_t;

   state_t          state;
   state_t          nxt;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  gnt_idx;
   logic [IDW-1:0]  op_id;
   logic            gnt_any;
   logic            grant;
   logic [1:0]      op_iv;
   logic [CNTW-1:0] cnt;
   logic            is_mul;
   int              j;

   assign ALU_CE = 1'b1;

   // ALU_MODE/CMD hold the latched op, so they select the latency.
   assign is_mul = ALU_MODE &&
                   (ALU_CMD == CW'(9) || ALU_CMD == CW'(10));

   // Search starts just past the last winner, so every lane gets a turn.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      j       = 0;
      for (int k = 1; k <= NREQ; k++) begin
         j = (int'(ptr) + k) % NREQ;
         if (!gnt_any && REQ_VALID[j]) begin
            gnt_any = 1'b1;
            gnt_idx = IDW'(j);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= S_IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt           = state;
      grant         = 1'b0;
      REQ_READY     = '0;
      ALU_INP_VALID = 2'b00;
      BUSY          = 1'b1;
      unique case (state)
         S_IDLE: begin
            BUSY = 1'b0;
            // READY is held low while reset is asserted.
            if (gnt_any && RST) begin
               grant              = 1'b1;
               REQ_READY[gnt_idx] = 1'b1;
               nxt                = S_ISSUE;
            end
         end
         S_ISSUE: begin
            ALU_INP_VALID = op_iv;
            nxt           = S_WAIT;
         end
         S_WAIT: begin
            if (cnt == '0) nxt = S_CAPT;
         end
         S_CAPT: begin
            nxt = S_RESP;
         end
         S_RESP: begin
            if (RSP_READY) nxt = S_IDLE;
         end
         default: begin
            nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ptr       <= IDW'(NREQ - 1);
         op_id     <= '0;
         op_iv     <= '0;
         ALU_MODE  <= 1'b0;
         ALU_CMD   <= '0;
         ALU_OPA   <= '0;
         ALU_OPB   <= '0;
         ALU_CIN   <= 1'b0;
         cnt       <= '0;
         RSP_VALID <= 1'b0;
         RSP_ID    <= '0;
         RSP_RES   <= '0;
         RSP_FLAGS <= '0;
      end else begin
         if (grant) begin
            ptr      <= gnt_idx;
            op_id    <= gnt_idx;
            op_iv    <= REQ_INP_VALID[gnt_idx*2 +: 2];
            ALU_MODE <= REQ_MODE[gnt_idx];
            ALU_CMD  <= REQ_CMD[gnt_idx*CW +: CW];
            ALU_OPA  <= REQ_OPA[gnt_idx*DW +: DW];
            ALU_OPB  <= REQ_OPB[gnt_idx*DW +: DW];
            ALU_CIN  <= REQ_CIN[gnt_idx];
         end
         // WAIT lasts cnt+1 cycles, i.e. exactly the ALU latency.
         if (state == S_ISSUE) begin
            cnt <= is_mul ? CNTW'(MUL_LAT - 1) : CNTW'(LAT - 1);
         end else if (state == S_WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (state == S_CAPT) begin
            RSP_RES   <= ALU_RES;
            RSP_FLAGS <= ALU_FLAGS;
            RSP_ID    <= op_id;
            RSP_VALID <= 1'b1;
         end else if (state == S_RESP && RSP_READY) begin
            RSP_VALID <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed and random checks of alu_req_arbiter
// against a transaction-level model and a latency-accurate fake ALU.
module tb_alu_req_arbiter;
   localparam int DW = 8, CW = 4, NREQ = 4, LAT = 1, MUL_LAT = 2;
   localparam int IDW = $clog2(NREQ);

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [NREQ-1:0]    req_valid, req_ready, req_mode, req_cin;
   logic [NREQ*CW-1:0] req_cmd;
   logic [NREQ*2-1:0]  req_iv;
   logic [NREQ*DW-1:0] req_opa, req_opb;
   logic               alu_ce, alu_mode, alu_cin;
   logic [1:0]         alu_inp_valid;
   logic [CW-1:0]      alu_cmd;
   logic [DW-1:0]      alu_opa, alu_opb;
   logic [2*DW-1:0]    alu_res, rsp_res;
   logic [5:0]         alu_flags, rsp_flags;
   logic               rsp_valid, rsp_ready, busy;
   logic [IDW-1:0]     rsp_id;

   alu_req_arbiter #(.DW(DW), .CW(CW), .NREQ(NREQ), .LAT(LAT),
                     .MUL_LAT(MUL_LAT)) dut (
      .CLK(clk), .RST(rst_n),
      .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_MODE(req_mode),
      .REQ_CMD(req_cmd), .REQ_INP_VALID(req_iv), .REQ_OPA(req_opa),
      .REQ_OPB(req_opb), .REQ_CIN(req_cin),
      .ALU_CE(alu_ce), .ALU_INP_VALID(alu_inp_valid), .ALU_MODE(alu_mode),
      .ALU_CMD(alu_cmd), .ALU_OPA(alu_opa), .ALU_OPB(alu_opb),
      .ALU_CIN(alu_cin), .ALU_RES(alu_res), .ALU_FLAGS(alu_flags),
      .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_ID(rsp_id),
      .RSP_RES(rsp_res), .RSP_FLAGS(rsp_flags), .BUSY(busy)
   );

   // requester-side state
   logic          r_v    [NREQ];
   logic          r_mode [NREQ];
   logic [CW-1:0] r_cmd  [NREQ];
   logic [1:0]    r_iv   [NREQ];
   logic [DW-1:0] r_opa  [NREQ];
   logic [DW-1:0] r_opb  [NREQ];
   logic          r_cin  [NREQ];

   always_comb begin
      req_valid = '0;
      req_mode  = '0;
      req_cin   = '0;
      req_cmd   = '0;
      req_iv    = '0;
      req_opa   = '0;
      req_opb   = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]           = r_v[i];
         req_mode[i]            = r_mode[i];
         req_cin[i]             = r_cin[i];
         req_cmd[i*CW +: CW]    = r_cmd[i];
         req_iv[i*2 +: 2]       = r_iv[i];
         req_opa[i*DW +: DW]    = r_opa[i];
         req_opb[i*DW +: DW]    = r_opb[i];
      end
   end

   function automatic logic [21:0] alu_f(logic m, logic [3:0] c,
                                         logic [1:0] v, logic [7:0] a,
                                         logic [7:0] b, logic ci);
      logic [15:0] r;
      logic [5:0]  f;
      r = '0;
      f = 6'b100000;
      if (v != 2'b00) begin
         if (m) begin
            case (c)
               4'd0:    r = 16'(a) + 16'(b);
               4'd1:    r = 16'(a) + 16'(b) + 16'(ci);
               4'd9:    r = 16'(a) * 16'(b);
               4'd10:   r = (16'(a) + 16'd1) * (16'(b) + 16'd1);
               default: r = 16'(a) - 16'(b);
            endcase
         end else begin
            r = {c, 4'h0, a ^ b};
         end
         f = {1'b0, 1'b0, r[8], a > b, a < b, a == b};
      end
      return {f, r};
   endfunction

   function automatic int lat_of(logic m, logic [3:0] c);
      return (m && (c == 4'd9 || c == 4'd10)) ? MUL_LAT : LAT;
   endfunction

   // Fake ALU: hist[k] is the result of what it saw k+1 edges ago;
   // RES is only right exactly at the op's own latency.
   logic [21:0] hist [4];
   always @(posedge clk) begin
      hist[0] <= alu_f(alu_mode, alu_cmd, alu_inp_valid,
                       alu_opa, alu_opb, alu_cin);
      for (int k = 1; k < 4; k++) hist[k] <= hist[k-1];
   end
   always_comb begin
      {alu_flags, alu_res} = hist[lat_of(alu_mode, alu_cmd)];
   end

   int tests = 0, fails = 0;
   int ptr, since, lop, nresp, cur_id, last_id;
   bit outstanding, rand_mode, refill;
   logic [21:0] cur_exp, cur_alu;
   logic [1:0]  cur_iv;
   logic [15:0] last_res;
   logic [5:0]  last_flags;
   int glog[$];
   int wait_cnt[NREQ];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(int i, logic m, logic [3:0] c, logic [1:0] v,
                         logic [7:0] a, logic [7:0] b, logic ci);
      r_mode[i] = m; r_cmd[i] = c; r_iv[i] = v;
      r_opa[i] = a; r_opb[i] = b; r_cin[i] = ci;
      r_v[i] = 1'b1; wait_cnt[i] = 0;
   endtask

   task automatic new_op(int i);
      int s;
      logic [3:0] c;
      s = $urandom_range(0, 5);
      case (s)
         0:       c = 4'd9;
         1:       c = 4'd10;
         2:       c = 4'd0;
         default: c = 4'($urandom);
      endcase
      set_op(i, 1'($urandom), c,
             ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
             8'($urandom), 8'($urandom), 1'($urandom));
   endtask

   task automatic step();
      int pick, best, d;
      logic [NREQ-1:0] erdy;
      logic erv, hs;
      @(negedge clk);
      pick = -1;
      best = NREQ;
      if (!outstanding) begin
         for (int q = 0; q < NREQ; q++) begin
            d = (q - ptr - 1 + 2 * NREQ) % NREQ;
            if (r_v[q] && d < best) begin
               best = d;
               pick = q;
            end
         end
      end
      erdy = '0;
      if (pick >= 0) erdy[pick] = 1'b1;
      erv = outstanding && (since >= lop + 2);
      hs  = erv && rsp_ready;
      chk("req_ready", 32'(req_ready), 32'(erdy));
      chk("busy", 32'(busy), 32'(outstanding));
      chk("alu_ce", 32'(alu_ce), 1);
      chk("rsp_valid", 32'(rsp_valid), 32'(erv));
      chk("alu_inp_valid", 32'(alu_inp_valid),
          (outstanding && since == 0) ? 32'(cur_iv) : 32'd0);
      if (outstanding && since <= lop)
         chk("alu_op", 32'({alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin}),
             32'(cur_alu));
      if (erv) begin
         chk("rsp_id", 32'(rsp_id), 32'(cur_id));
         chk("rsp_res_flags", 32'({rsp_flags, rsp_res}), 32'(cur_exp));
      end
      if (hs) begin
         last_res   = rsp_res;
         last_flags = rsp_flags;
         last_id    = int'(rsp_id);
      end
      @(posedge clk);
      #1;
      if (pick >= 0) begin
         for (int q = 0; q < NREQ; q++)
            if (q != pick && r_v[q]) wait_cnt[q]++;
         chk("rr_wait", 32'(wait_cnt[pick] <= NREQ - 1), 1);
         wait_cnt[pick] = 0;
         glog.push_back(pick);
         ptr         = pick;
         outstanding = 1'b1;
         since       = 0;
         cur_id      = pick;
         cur_iv      = r_iv[pick];
         cur_alu     = {r_mode[pick], r_cmd[pick], r_opa[pick],
                        r_opb[pick], r_cin[pick]};
         cur_exp     = alu_f(r_mode[pick], r_cmd[pick], r_iv[pick],
                             r_opa[pick], r_opb[pick], r_cin[pick]);
         lop         = lat_of(r_mode[pick], r_cmd[pick]);
         if (refill) new_op(pick);
         else        r_v[pick] = 1'b0;
      end else if (outstanding) begin
         if (hs) begin
            outstanding = 1'b0;
            nresp++;
         end else begin
            since++;
         end
      end
      if (rand_mode) begin
         for (int q = 0; q < NREQ; q++) begin
            if (!r_v[q] && $urandom_range(0, 2) == 0) begin
               new_op(q);
            end else if (r_v[q] && outstanding &&
                         $urandom_range(0, 15) == 0) begin
               r_v[q] = 1'b0;
               wait_cnt[q] = 0;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic run_until(int target, int budget, input string tag);
      int c;
      c = 0;
      while (nresp < target && c < budget) begin
         step();
         c++;
      end
      chk(tag, 32'(nresp >= target), 1);
   endtask

   task automatic drain(input string tag);
      int c;
      c = 0;
      while (outstanding && c < 40) begin
         step();
         c++;
      end
      chk(tag, 32'(outstanding), 0);
   endtask

   task automatic do_reset();
      for (int i = 0; i < NREQ; i++) r_v[i] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ctl", 32'({req_ready, alu_inp_valid, alu_mode, alu_cmd,
                          alu_opa, alu_opb, alu_cin, rsp_valid, rsp_id,
                          busy}), 0);
      chk("rst_rsp", 32'({rsp_flags, rsp_res}), 0);
      chk("rst_ce", 32'(alu_ce), 1);
      outstanding = 1'b0;
      since = 0;
      ptr = NREQ - 1;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, n0, g0;
      for (int i = 0; i < NREQ; i++) begin
         r_v[i] = 1'b0; r_mode[i] = 1'b0; r_cmd[i] = '0; r_iv[i] = '0;
         r_opa[i] = '0; r_opb[i] = '0; r_cin[i] = 1'b0; wait_cnt[i] = 0;
      end
      rsp_ready = 1'b1;
      rand_mode = 1'b0;
      refill = 1'b0;
      nresp = 0; since = 0; lop = LAT; cur_id = 0; last_id = -1;
      cur_exp = '0; cur_alu = '0; cur_iv = '0;
      last_res = '0; last_flags = '0;
      outstanding = 1'b0;
      ptr = NREQ - 1;
      #1;
      do_reset();

      // reset in the middle of a multiply's WAIT
      set_op(2, 1'b1, 4'd9, 2'b11, 8'd7, 8'd5, 1'b0);
      c = 0;
      while (!(outstanding && since == 1) && c < 10) begin
         step();
         c++;
      end
      chk("t1_reach_wait", 32'(outstanding && since == 1), 1);
      n0 = nresp;
      do_reset();
      repeat (8) step();
      chk("t1_no_rsp", 32'(nresp), 32'(n0));

      // fairness from reset: all lanes always requesting
      glog.delete();
      refill = 1'b1;
      for (int i = 0; i < NREQ; i++) new_op(i);
      run_until(nresp + 5, 60, "t4_done");
      refill = 1'b0;
      for (int i = 0; i < NREQ; i++) r_v[i] = 1'b0;
      drain("t4_drain");
      chk("t4_len", 32'(glog.size() >= 5), 1);
      for (int k = 0; k < 5 && k < glog.size(); k++)
         chk("t4_order", 32'(glog[k]), 32'(k % NREQ));

      // single add on lane 1
      set_op(1, 1'b1, 4'd0, 2'b11, 8'h0F, 8'h01, 1'b0);
      run_until(nresp + 1, 30, "t2_done");
      chk("t2_id", 32'(last_id), 1);
      chk("t2_res", 32'(last_res), 32'h0010);
      chk("t2_flags", 32'(last_flags), 32'h04);

      // multiply must be captured at MUL_LAT
      set_op(2, 1'b1, 4'd9, 2'b11, 8'd3, 8'd4, 1'b0);
      run_until(nresp + 1, 30, "t3_done");
      chk("t3_id", 32'(last_id), 2);
      chk("t3_res", 32'(last_res), 32'h000C);
      chk("t3_flags", 32'(last_flags), 32'h02);

      // response backpressure with another request waiting
      set_op(0, 1'b0, 4'd3, 2'b11, 8'hA5, 8'h3C, 1'b1);
      set_op(1, 1'b1, 4'd10, 2'b00, 8'h11, 8'h22, 1'b0);
      rsp_ready = 1'b0;
      c = 0;
      while (!(outstanding && since >= lop + 2) && c < 20) begin
         step();
         c++;
      end
      chk("t5_reach_resp", 32'(outstanding && since >= lop + 2), 1);
      g0 = glog.size();
      repeat (5) step();
      chk("t5_nogrant", 32'(glog.size()), 32'(g0));
      chk("t5_hold", 32'(rsp_valid), 1);
      rsp_ready = 1'b1;
      run_until(nresp + 2, 40, "t5_done");
      chk("t5_err_flag", 32'(last_flags), 32'h20);

      // wrap from lane 3 to lane 0
      set_op(3, 1'b1, 4'd1, 2'b11, 8'hFF, 8'h01, 1'b1);
      run_until(nresp + 1, 30, "t6a_done");
      chk("t6_first", 32'(glog[glog.size()-1]), 3);
      set_op(0, 1'b1, 4'd0, 2'b11, 8'h80, 8'h80, 1'b0);
      run_until(nresp + 1, 30, "t6b_done");
      chk("t6_wrap", 32'(glog[glog.size()-1]), 0);
      chk("t6_res", 32'(last_res), 32'h0100);

      // random traffic
      rand_mode = 1'b1;
      repeat (600) step();
      rand_mode = 1'b0;
      for (int i = 0; i < NREQ; i++) r_v[i] = 1'b0;
      rsp_ready = 1'b1;
      drain("rand_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
